// File: rtl/dmem_responder.sv
// Data-memory responder: valid/ready request, LATENCY wait states, then a held response.
// Optional misalignment reporting is enabled by defining DMEM_ALIGN_CHECK_EN.
module dmem_responder #(
  parameter int ADDR_W  = 10,
  parameter int LATENCY = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_wena,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [1:0]  req_cs,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  localparam logic [3:0] LAT = 4'(LATENCY);

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        wena_q, wena_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [1:0]  cs_q, cs_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;

  logic [31:0] mem [2**ADDR_W];

  logic              acc_wena;
  logic [31:0]       acc_addr;
  logic [31:0]       acc_wdata;
  logic [1:0]        acc_cs;
  logic              is_half, is_byte;
  logic [1:0]        acc_lane;
  logic              acc_err;
  logic [3:0]        acc_be;
  logic [31:0]       wr_word;
  logic [31:0]       rd_word;
  logic [31:0]       rd_shift;
  logic [31:0]       load_data;
  logic [ADDR_W-1:0] word_idx;
  logic              enter_resp;
  logic              mem_we;
  logic              unused_addr;

  // With LATENCY==0 the access happens on the accept edge, so use the live request in IDLE.
  always_comb begin
    if (state_q == S_IDLE) begin
      acc_wena  = req_wena;
      acc_addr  = req_addr;
      acc_wdata = req_wdata;
      acc_cs    = req_cs;
    end else begin
      acc_wena  = wena_q;
      acc_addr  = addr_q;
      acc_wdata = wdata_q;
      acc_cs    = cs_q;
    end
  end

  assign is_half     = (acc_cs == 2'b01);
  assign is_byte     = (acc_cs == 2'b10);
  assign word_idx    = acc_addr[ADDR_W+1:2];
  assign unused_addr = ^acc_addr[31:ADDR_W+2];

`ifdef DMEM_ALIGN_CHECK_EN
  assign acc_lane = acc_addr[1:0];
  assign acc_err  = (is_half && acc_addr[0]) ||
                    (!is_half && !is_byte && (acc_addr[1:0] != 2'b00));
`else
  assign acc_lane = is_byte ? acc_addr[1:0] : (is_half ? {acc_addr[1], 1'b0} : 2'b00);
  assign acc_err  = 1'b0;
`endif

  always_comb begin
    acc_be  = 4'b1111;
    wr_word = acc_wdata;
    if (is_byte) begin
      acc_be  = 4'b0001 << acc_lane;
      wr_word = {4{acc_wdata[7:0]}};
    end else if (is_half) begin
      acc_be  = acc_lane[1] ? 4'b1100 : 4'b0011;
      wr_word = {2{acc_wdata[15:0]}};
    end
  end

  assign rd_word  = mem[word_idx];
  assign rd_shift = rd_word >> {acc_lane, 3'b000};

  always_comb begin
    load_data = rd_word;
    if (is_byte) begin
      load_data = {24'h0, rd_shift[7:0]};
    end else if (is_half) begin
      load_data = {16'h0, rd_shift[15:0]};
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    wena_d     = wena_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    cs_d       = cs_q;
    rdata_d    = rdata_q;
    err_d      = err_q;
    enter_resp = 1'b0;
    req_ready  = 1'b0;
    rsp_valid  = 1'b0;
    case (state_q)
      S_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          wena_d  = req_wena;
          addr_d  = req_addr;
          wdata_d = req_wdata;
          cs_d    = req_cs;
          if (LAT == 4'd0) begin
            enter_resp = 1'b1;
            state_d    = S_RESP;
          end else begin
            cnt_d   = LAT;
            state_d = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          enter_resp = 1'b1;
          state_d    = S_RESP;
        end
      end
      S_RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (enter_resp) begin
      err_d   = acc_err;
      rdata_d = (acc_wena || acc_err) ? 32'h0 : load_data;
    end
  end

  assign mem_we    = enter_resp && acc_wena && !acc_err;
  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      wena_q  <= 1'b0;
      addr_q  <= 32'h0;
      wdata_q <= 32'h0;
      cs_q    <= 2'b00;
      rdata_q <= 32'h0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      wena_q  <= wena_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      cs_q    <= cs_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // Array contents survive reset; only the write strobe is gated by the FSM.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int b = 0; b < 4; b++) begin
        if (acc_be[b]) begin
          mem[word_idx][8*b +: 8] <= wr_word[8*b +: 8];
        end
      end
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed self-checking bench for dmem_responder: one LATENCY=2 instance and one LATENCY=0 instance.
module tb_dmem_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_wena;
  logic [31:0] req_addr, req_wdata;
  logic [1:0]  req_cs;
  logic        rsp_valid, rsp_ready, rsp_err;
  logic [31:0] rsp_rdata;

  logic        req_valid_z, req_ready_z, req_wena_z;
  logic [31:0] req_addr_z, req_wdata_z;
  logic [1:0]  req_cs_z;
  logic        rsp_valid_z, rsp_ready_z, rsp_err_z;
  logic [31:0] rsp_rdata_z;

  int n_cmp  = 0;
  int n_fail = 0;
  int lat_obs;

  always #5 clk = ~clk;

  dmem_responder #(.ADDR_W(10), .LATENCY(2)) u_dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_wena(req_wena),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_cs(req_cs),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
  );

  dmem_responder #(.ADDR_W(10), .LATENCY(0)) u_dut_z (
    .clk(clk), .rst(rst),
    .req_valid(req_valid_z), .req_ready(req_ready_z), .req_wena(req_wena_z),
    .req_addr(req_addr_z), .req_wdata(req_wdata_z), .req_cs(req_cs_z),
    .rsp_valid(rsp_valid_z), .rsp_ready(rsp_ready_z),
    .rsp_rdata(rsp_rdata_z), .rsp_err(rsp_err_z)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    n_cmp++;
    assert (observed === expected) else begin
      n_fail++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // Issues one request and returns at the first negedge where rsp_valid is seen; lat_obs counts
  // the edges after the accept edge, so it equals LATENCY.
  task automatic applyStimulus(input logic wena, input logic [31:0] addr, input logic [31:0] wdata,
                               input logic [1:0] cs, input logic early_rdy);
    int n;
    @(negedge clk);
    req_valid = 1'b1;
    req_wena  = wena;
    req_addr  = addr;
    req_wdata = wdata;
    req_cs    = cs;
    rsp_ready = early_rdy;
    n = 0;
    while (!req_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    lat_obs = 0;
    while (!rsp_valid && lat_obs < 40) begin
      @(negedge clk);
      lat_obs++;
    end
  endtask

  task automatic finishRsp(input string tag, input logic [31:0] exp_rdata, input logic exp_err);
    checkOutput({tag, "_lat"}, 32'(lat_obs), 32'd2);
    checkOutput({tag, "_valid"}, {31'h0, rsp_valid}, 32'd1);
    checkOutput({tag, "_rdata"}, rsp_rdata, exp_rdata);
    checkOutput({tag, "_err"}, {31'h0, rsp_err}, {31'h0, exp_err});
    rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rsp_ready = 1'b0;
    checkOutput({tag, "_done"}, {31'h0, rsp_valid}, 32'd0);
  endtask

  initial begin
    rst = 1'b1;
    req_valid = 1'b0; req_wena = 1'b0; req_addr = 32'h0; req_wdata = 32'h0; req_cs = 2'b00;
    rsp_ready = 1'b0;
    req_valid_z = 1'b0; req_wena_z = 1'b0; req_addr_z = 32'h0; req_wdata_z = 32'h0; req_cs_z = 2'b00;
    rsp_ready_z = 1'b0;

    repeat (2) @(negedge clk);
    checkOutput("rst_req_ready", {31'h0, req_ready}, 32'd1);
    checkOutput("rst_rsp_valid", {31'h0, rsp_valid}, 32'd0);
    checkOutput("rst_rdata", rsp_rdata, 32'h0);
    checkOutput("rst_err", {31'h0, rsp_err}, 32'd0);
    rst = 1'b0;

    $display("[TB] store/load word");
    applyStimulus(1'b1, 32'h10, 32'hDEADBEEF, 2'b00, 1'b0);
    finishRsp("st_w10", 32'h0, 1'b0);
    applyStimulus(1'b0, 32'h10, 32'h0, 2'b00, 1'b1);
    finishRsp("ld_w10", 32'hDEADBEEF, 1'b0);

    $display("[TB] byte store over word");
    applyStimulus(1'b1, 32'h10, 32'h11223344, 2'b00, 1'b0);
    finishRsp("st_w10b", 32'h0, 1'b0);
    applyStimulus(1'b1, 32'h13, 32'h123456AA, 2'b10, 1'b0);
    finishRsp("st_b13", 32'h0, 1'b0);
    applyStimulus(1'b0, 32'h10, 32'h0, 2'b00, 1'b0);
    finishRsp("ld_w10b", 32'hAA223344, 1'b0);
    applyStimulus(1'b0, 32'h13, 32'h0, 2'b10, 1'b0);
    finishRsp("ld_b13", 32'h000000AA, 1'b0);
    applyStimulus(1'b0, 32'h12, 32'h0, 2'b01, 1'b0);
    finishRsp("ld_h12", 32'h0000AA22, 1'b0);

    $display("[TB] response backpressure");
    applyStimulus(1'b0, 32'h10, 32'h0, 2'b00, 1'b0);
    req_valid = 1'b1; req_wena = 1'b1; req_addr = 32'h40; req_wdata = 32'h99999999; req_cs = 2'b00;
    for (int i = 0; i < 5; i++) begin
      checkOutput("hold_valid", {31'h0, rsp_valid}, 32'd1);
      checkOutput("hold_rdata", rsp_rdata, 32'hAA223344);
      checkOutput("hold_req_ready", {31'h0, req_ready}, 32'd0);
      @(negedge clk);
    end
    rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rsp_ready = 1'b0;
    checkOutput("hs_valid_low", {31'h0, rsp_valid}, 32'd0);
    checkOutput("hs_not_accepted", {31'h0, req_ready}, 32'd1);
    req_valid = 1'b0;

    $display("[TB] reset during wait");
    applyStimulus(1'b1, 32'h20, 32'h12345678, 2'b00, 1'b0);
    finishRsp("st_w20", 32'h0, 1'b0);
    applyStimulus(1'b0, 32'h20, 32'h0, 2'b00, 1'b0);
    finishRsp("ld_w20", 32'h12345678, 1'b0);
    @(negedge clk);
    req_valid = 1'b1; req_wena = 1'b1; req_addr = 32'h20; req_wdata = 32'h00000055; req_cs = 2'b00;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    checkOutput("wait_req_ready", {31'h0, req_ready}, 32'd0);
    rst = 1'b1;
    #1;
    checkOutput("midrst_req_ready", {31'h0, req_ready}, 32'd1);
    checkOutput("midrst_valid", {31'h0, rsp_valid}, 32'd0);
    checkOutput("midrst_rdata", rsp_rdata, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    applyStimulus(1'b0, 32'h20, 32'h0, 2'b00, 1'b0);
    finishRsp("ld_w20_after_rst", 32'h12345678, 1'b0);

    $display("[TB] address aliasing");
    applyStimulus(1'b1, 32'h1000, 32'hCAFEF00D, 2'b00, 1'b0);
    finishRsp("st_alias", 32'h0, 1'b0);
    applyStimulus(1'b0, 32'h0, 32'h0, 2'b00, 1'b0);
    finishRsp("ld_alias", 32'hCAFEF00D, 1'b0);

    $display("[TB] misaligned accesses");
    applyStimulus(1'b1, 32'h20, 32'hFFFFFFFF, 2'b00, 1'b0);
    finishRsp("st_w20_ones", 32'h0, 1'b0);
`ifdef DMEM_ALIGN_CHECK_EN
    applyStimulus(1'b1, 32'h21, 32'h0000BEEF, 2'b01, 1'b0);
    finishRsp("st_h21", 32'h0, 1'b1);
    applyStimulus(1'b0, 32'h20, 32'h0, 2'b00, 1'b0);
    finishRsp("ld_w20_mis", 32'hFFFFFFFF, 1'b0);
    applyStimulus(1'b0, 32'h22, 32'h0, 2'b00, 1'b0);
    finishRsp("ld_w22", 32'h0, 1'b1);
`else
    applyStimulus(1'b1, 32'h21, 32'h0000BEEF, 2'b01, 1'b0);
    finishRsp("st_h21", 32'h0, 1'b0);
    applyStimulus(1'b0, 32'h20, 32'h0, 2'b00, 1'b0);
    finishRsp("ld_w20_mis", 32'hFFFFBEEF, 1'b0);
    applyStimulus(1'b0, 32'h22, 32'h0, 2'b00, 1'b0);
    finishRsp("ld_w22", 32'hFFFFBEEF, 1'b0);
`endif

    $display("[TB] zero-latency instance");
    @(negedge clk);
    req_valid_z = 1'b1; req_wena_z = 1'b1; req_addr_z = 32'h8; req_wdata_z = 32'h0BADF00D; req_cs_z = 2'b00;
    checkOutput("z_idle_ready", {31'h0, req_ready_z}, 32'd1);
    @(posedge clk);
    @(negedge clk);
    req_valid_z = 1'b0;
    checkOutput("z_st_valid", {31'h0, rsp_valid_z}, 32'd1);
    checkOutput("z_st_req_ready", {31'h0, req_ready_z}, 32'd0);
    rsp_ready_z = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rsp_ready_z = 1'b0;
    checkOutput("z_st_done", {31'h0, rsp_valid_z}, 32'd0);
    req_valid_z = 1'b1; req_wena_z = 1'b0; req_addr_z = 32'h8; req_wdata_z = 32'h0; req_cs_z = 2'b00;
    @(posedge clk);
    @(negedge clk);
    req_valid_z = 1'b0;
    checkOutput("z_ld_valid", {31'h0, rsp_valid_z}, 32'd1);
    checkOutput("z_ld_rdata", rsp_rdata_z, 32'h0BADF00D);
    checkOutput("z_ld_err", {31'h0, rsp_err_z}, 32'd0);
    rsp_ready_z = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rsp_ready_z = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
